accum_wr_ctrl: RTL and testbench
================================

# accum_wr_ctrl

Write-side controller for the image coprocessor's ping-pong row accumulator (256 pixels × 12-bit RGB444 = 3072-bit rows). It accepts a pixel stream over a valid/ready handshake and generates the accumulator's write enable, pixel data and column-count/swap control. It raises one bank-write request per completed row and applies back-pressure so an unwritten row is never overwritten. Frame sequencing (start, row count, done) lives here; the accumulator and the row bank are external.

## Interface
- ROWS, 240: rows per frame (1..2^ROW_AW).
- ROW_AW, 8: row address width.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- abort  in  1  synchronous abort; returns to IDLE
- pix_valid  in  1  upstream pixel valid
- pix_data  in  12  pixel {R[11:8],G[7:4],B[3:0]}
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- acc_we  out  1  accumulator shift enable
- acc_wdata  out  12  accumulator pixel data
- acc_col_cnt  out  8  accumulator swap control; 0 for exactly one cycle per completed row, else 8'hFF
- row_wr_req  out  1  completed row is on the accumulator output, write it to the bank
- row_wr_addr  out  ROW_AW  row index for the pending write
- row_wr_ack  in  1  bank write done; clears row_wr_req
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when the last row's write is acked

## Operation
- Internal counters: pix_idx (8-bit, 0..255, wraps), row_idx (ROW_AW bits), req_pend (drives row_wr_req).
- The accumulator toggles its bank on every cycle where acc_col_cnt==0. acc_col_cnt must therefore be 8'hFF at all times except the SWAP cycle.
- States:
  - IDLE: on start, clear pix_idx and row_idx, go to FILL. A start in any other state is ignored.
  - FILL:
    - pix_ready = !(pix_idx==255 && req_pend).
    - On accept, increment pix_idx.
    - On accept at pix_idx==255, go to SWAP.
  - SWAP (1 cycle): acc_col_cnt=0, pix_ready=0. Next cycle: set req_pend with row_wr_addr=row_idx.
    - If row_idx==ROWS-1, go to DRAIN.
    - Otherwise increment row_idx and go to FILL.
  - DRAIN: pix_ready=0. On row_wr_ack, go to DONE.
  - DONE (1 cycle): frame_done=1, then go to IDLE.
- acc_we = pix_valid & pix_ready (combinational). acc_wdata = pix_data. pix_ready=0 in IDLE.
- req_pend clears on a row_wr_ack cycle. row_wr_ack while req_pend==0 is ignored.
- If the set and clear of req_pend coincide (the old request is acked in the same cycle a new one is raised), the new request wins.
- row_wr_addr holds its value while req_pend is set.
- abort in any state takes effect next cycle: IDLE, req_pend=0, counters cleared, acc_col_cnt=8'hFF. Partial row contents in the accumulator are don't-care. abort overrides a same-cycle start.

## Timing
- Reset values:
  - pix_ready=0, acc_we=0, acc_wdata=0, acc_col_cnt=8'hFF
  - row_wr_req=0, row_wr_addr=0, busy=0, frame_done=0
  - state IDLE
- start at cycle t → pix_ready may be high at t+1.
- 256th accept at cycle t:
  - cycle t+1: SWAP, acc_col_cnt=0.
  - cycle t+2: row_wr_req=1, the next row's pixel 0 may be accepted.
- Peak throughput: 256 pixels per 257 cycles.
- Back-pressure: the only stall points are pix_idx==255 with a pending request, plus the SWAP cycle.
- Last row: frame_done asserts the cycle after its row_wr_ack. busy falls the cycle after frame_done.
- Reset asserted mid-frame clears all state immediately (asynchronous), including row_wr_req.

## Test plan
- ROWS=2, continuous valid, row_wr_ack 1 cycle after each req:
  - acc_col_cnt=0 exactly on cycles 257 and 514 after start
  - row_wr_addr 0 then 1
  - frame_done once
  - 512 acc_we pulses
- Row_wr_ack withheld 400 cycles: pix_ready low with pix_idx==255 until the ack, then the 256th pixel is accepted. No second swap before the ack.
- Random pix_valid gaps: acc_wdata sequence equals the accepted pix_data in order. acc_col_cnt never 0 outside SWAP, and never 0 for 2 consecutive cycles.
- start pulsed during FILL: no effect on row_idx or pix_idx. abort at pix_idx=100: IDLE next cycle, row_wr_req=0. A fresh start restarts at row 0.
- rst_n asserted mid-row with req_pend=1: all outputs return to reset values asynchronously.
- Same-cycle row_wr_ack and new request: row_wr_req stays 1 with the new row_wr_addr.

Source files
------------

// File: rtl/accum_wr_ctrl_if.sv
// accum_wr_ctrl_if: pixel stream, accumulator write and row-bank request signals
interface accum_wr_ctrl_if #(
    parameter int ROW_AW = 8
);
    logic              pix_valid;
    logic              pix_ready;
    logic [11:0]       pix_data;
    logic              acc_we;
    logic [11:0]       acc_wdata;
    logic [7:0]        acc_col_cnt;
    logic              row_wr_req;
    logic [ROW_AW-1:0] row_wr_addr;
    logic              row_wr_ack;

    modport master (
        input  pix_valid, pix_data, row_wr_ack,
        output pix_ready, acc_we, acc_wdata, acc_col_cnt, row_wr_req, row_wr_addr
    );

    modport slave (
        output pix_valid, pix_data, row_wr_ack,
        input  pix_ready, acc_we, acc_wdata, acc_col_cnt, row_wr_req, row_wr_addr
    );
endinterface

// File: rtl/accum_wr_ctrl.sv
// accum_wr_ctrl: write-side frame/row sequencer for the ping-pong row accumulator
module accum_wr_ctrl #(
    parameter int ROWS   = 240,
    parameter int ROW_AW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    accum_wr_ctrl_if.master        bus,
    output logic                   busy,
    output logic                   frame_done
);
    typedef enum logic [2:0] {IDLE, FILL, SWAP, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        pix_idx;
    logic [ROW_AW-1:0] row_idx;
    logic              req_pend;
    logic              rdy;
    logic              accept;
    logic              last_row;

    assign last_row = row_idx == ROW_AW'(ROWS - 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake/accumulator outputs; abort beats everything
    always_comb begin
        rdy             = state == FILL && !(pix_idx == 8'hFF && req_pend);
        accept          = bus.pix_valid && rdy;
        bus.pix_ready   = rdy;
        bus.acc_we      = accept;
        bus.acc_wdata   = bus.pix_data;
        bus.acc_col_cnt = state == SWAP ? 8'h00 : 8'hFF;
        bus.row_wr_req  = req_pend;
        busy            = state != IDLE;
        frame_done      = state == DONE;
        state_nxt       = state;
        case (state)
            IDLE:    state_nxt = start ? FILL : IDLE;
            FILL:    state_nxt = accept && pix_idx == 8'hFF ? SWAP : FILL;
            SWAP:    state_nxt = last_row ? DRAIN : FILL;
            DRAIN:   state_nxt = bus.row_wr_ack && req_pend ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Pixel/row counters and the pending row-write request (new request wins over ack)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_idx         <= '0;
            row_idx         <= '0;
            req_pend        <= 1'b0;
            bus.row_wr_addr <= '0;
        end else if (abort) begin
            pix_idx  <= '0;
            row_idx  <= '0;
            req_pend <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                pix_idx <= '0;
                row_idx <= '0;
            end
            if (accept) pix_idx <= pix_idx + 8'd1;
            if (state == SWAP) begin
                req_pend        <= 1'b1;
                bus.row_wr_addr <= row_idx;
                if (!last_row) row_idx <= row_idx + 1'b1;
            end else if (bus.row_wr_ack) begin
                req_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_accum_wr_ctrl.sv
// tb_accum_wr_ctrl: directed checks of frame sequencing, back-pressure, abort and reset
module tb_accum_wr_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, frame_done;

    accum_wr_ctrl_if #(.ROW_AW(8)) bus ();

    accum_wr_ctrl #(.ROWS(2), .ROW_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc, zero_cnt, zero_first, zero_last, acc_n, done_cnt, done_cyc;
    int stall_cnt, bad_seq, bad_zero, bad_req, req0_cnt;
    logic busy_after;
    logic [7:0] addr_seen[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_f(input int n);
        return 12'((n * 97 + 13) ^ (n >> 2));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer k pixels, holding valid until each is taken
    task automatic feed(input int k);
        int n = 0;
        int g = 0;
        bus.pix_valid = 1'b1;
        while (n < k && g < 2000) begin
            @(negedge clk);
            if (bus.pix_ready) n++;
            tick;
            g++;
        end
        bus.pix_valid = 1'b0;
        if (n < k) chk("feed_timeout", 32'(n), 32'(k));
    endtask

    // One full frame: start at cycle 0, acks one cycle after a request once cycle >= hold
    task automatic run_frame(input int hold, input bit rnd, input bit ack_swap, input int max_c);
        bit acc, prev_acc, prev_zero, prev_req, swap_next;
        cyc = 0; zero_cnt = 0; zero_first = -1; zero_last = -1; acc_n = 0;
        done_cnt = 0; done_cyc = -1; stall_cnt = 0; bad_seq = 0; bad_zero = 0;
        bad_req = 0; req0_cnt = 0; busy_after = 1'b1; addr_seen.delete();
        prev_acc = 0; prev_zero = 0; prev_req = 0; swap_next = 0;
        tick;
        start = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_data = pix_f(0);
        bus.row_wr_ack = 1'b0;
        while (cyc < max_c && !(done_cnt > 0 && cyc > done_cyc)) begin
            tick;
            start = 1'b0;
            bus.row_wr_ack = (prev_req && !bus.row_wr_ack && cyc + 1 >= hold) || (ack_swap && swap_next);
            if (!(bus.pix_valid && !prev_acc) || acc_n == 0 && cyc == 0)
                bus.pix_valid = acc_n < 512 && (!rnd || $urandom_range(0, 3) != 0);
            bus.pix_data = pix_f(acc_n);
            @(negedge clk);
            cyc++;
            acc = bus.pix_valid && bus.pix_ready;
            if (bus.acc_we !== acc) bad_seq++;
            if (acc && bus.acc_wdata !== pix_f(acc_n)) bad_seq++;
            if (bus.acc_col_cnt == 8'h00) begin
                zero_cnt++;
                if (zero_first < 0) zero_first = cyc;
                zero_last = cyc;
                if (!swap_next || prev_zero) bad_zero++;
            end else if (bus.acc_col_cnt !== 8'hFF) bad_zero++;
            if (prev_zero && !bus.row_wr_req) bad_req++;
            if (bus.row_wr_req && !prev_req) addr_seen.push_back(bus.row_wr_addr);
            if (bus.row_wr_req && bus.row_wr_addr == 8'd0) req0_cnt++;
            if (bus.pix_valid && !bus.pix_ready && bus.acc_col_cnt != 8'h00) stall_cnt++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = busy;
            if (acc) acc_n++;
            swap_next = acc && acc_n % 256 == 0;
            prev_acc = acc;
            prev_zero = bus.acc_col_cnt == 8'h00;
            prev_req = bus.row_wr_req;
        end
        tick;
        bus.pix_valid = 1'b0;
        bus.row_wr_ack = 1'b0;
    endtask

    task automatic chk_addrs;
        chk("addr_count", 32'(addr_seen.size()), 32'd2);
        if (addr_seen.size() == 2) begin
            chk("addr_row0", 32'(addr_seen[0]), 32'd0);
            chk("addr_row1", 32'(addr_seen[1]), 32'd1);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data = 12'h000;
        bus.row_wr_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_acc_we", 32'(bus.acc_we), 32'd0);
        chk("rst_acc_wdata", 32'(bus.acc_wdata), 32'd0);
        chk("rst_col_cnt", 32'(bus.acc_col_cnt), 32'hFF);
        chk("rst_req", 32'(bus.row_wr_req), 32'd0);
        chk("rst_addr", 32'(bus.row_wr_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        tick;
        rst_n = 1'b1;

        run_frame(0, 0, 0, 1000);
        chk("t1_zero_cnt", 32'(zero_cnt), 32'd2);
        chk("t1_zero_first", 32'(zero_first), 32'd257);
        chk("t1_zero_last", 32'(zero_last), 32'd514);
        chk("t1_we_pulses", 32'(acc_n), 32'd512);
        chk("t1_we_seq", 32'(bad_seq), 32'd0);
        chk("t1_zero_ok", 32'(bad_zero), 32'd0);
        chk("t1_stalls", 32'(stall_cnt), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_done_cyc", 32'(done_cyc), 32'd517);
        chk("t1_busy_after", 32'(busy_after), 32'd0);
        chk_addrs();

        run_frame(658, 0, 0, 1500);
        chk("t2_stalls", 32'(stall_cnt), 32'd146);
        chk("t2_req0_cycles", 32'(req0_cnt), 32'd401);
        chk("t2_zero_cnt", 32'(zero_cnt), 32'd2);
        chk("t2_zero_last", 32'(zero_last), 32'd660);
        chk("t2_we_pulses", 32'(acc_n), 32'd512);
        chk("t2_done_cyc", 32'(done_cyc), 32'd663);
        chk_addrs();

        run_frame(0, 1, 0, 4000);
        chk("t3_accepts", 32'(acc_n), 32'd512);
        chk("t3_wdata_seq", 32'(bad_seq), 32'd0);
        chk("t3_zero_ok", 32'(bad_zero), 32'd0);
        chk("t3_zero_cnt", 32'(zero_cnt), 32'd2);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        run_frame(0, 0, 1, 1000);
        chk("t6_req_after_swap", 32'(bad_req), 32'd0);
        chk("t6_done_cyc", 32'(done_cyc), 32'd517);
        chk_addrs();

        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(50);
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(206);
        @(negedge clk);
        chk("t4_swap_after_256", 32'(bus.acc_col_cnt), 32'd0);
        tick;
        feed(100);
        @(negedge clk);
        chk("t4_req_pending", 32'(bus.row_wr_req), 32'd1);
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_req", 32'(bus.row_wr_req), 32'd0);
        chk("t4_abort_ready", 32'(bus.pix_ready), 32'd0);
        tick;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_beats_start", 32'(busy), 32'd0);
        run_frame(0, 0, 0, 1000);
        chk("t4_restart_swap", 32'(zero_first), 32'd257);
        chk("t4_restart_done", 32'(done_cnt), 32'd1);
        chk_addrs();

        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(256);
        feed(30);
        @(negedge clk);
        chk("t5_pre_req", 32'(bus.row_wr_req), 32'd1);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        #2;
        bus.pix_data = 12'h000;
        rst_n = 1'b0;
        #1;
        chk("t5_req", 32'(bus.row_wr_req), 32'd0);
        chk("t5_addr", 32'(bus.row_wr_addr), 32'd0);
        chk("t5_ready", 32'(bus.pix_ready), 32'd0);
        chk("t5_acc_we", 32'(bus.acc_we), 32'd0);
        chk("t5_acc_wdata", 32'(bus.acc_wdata), 32'd0);
        chk("t5_col_cnt", 32'(bus.acc_col_cnt), 32'hFF);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(frame_done), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
